tff_counter: RTL and testbench
==============================

# tff_counter

Parametrised synchronous counter generalising the enable-gated toggle flip-flop to a WIDTH-bit register.
- Counts up or down, supports parallel load, and wraps at a programmable modulus or saturates at the bounds.
- Reports a terminal-count flag and a sticky overflow flag.
- Serves as the general counting/dividing element for later lab datapaths: timers, clock-enable dividers and event counters.

## Interface
Parameters:
- WIDTH, 4: counter width in bits; valid range ≥ 1.
- MODULUS, 16: count range is 0..MODULUS-1; 2 ≤ MODULUS ≤ 2^WIDTH. MAX below means MODULUS-1.
- SATURATE, 0: 0 = wrap at the bounds, 1 = hold at the bounds.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- enable  in  1  count enable; the counter advances only when high.
- up  in  1  direction: 1 = increment, 0 = decrement.
- load  in  1  parallel-load strobe.
- d  in  WIDTH  load value.
- clr_ovf  in  1  clears the sticky overflow flag.
- q  out  WIDTH  registered count.
- tc  out  1  combinational terminal count.
- ovf  out  1  registered sticky overflow flag.

## Operation
- Register priority at each rising edge of clk: rst low, then load, then enable, otherwise hold.
- rst low:
  - q ← 0 and ovf ← 0.
  - load, enable and clr_ovf are ignored in that cycle.
- load high:
  - q ← d if d ≤ MAX, else q ← MAX (clamp).
  - load takes effect regardless of enable.
  - load does not set ovf.
- Counting (enable high, load low), WIDTH-bit unsigned arithmetic:
  - up=1, q < MAX: q ← q+1.
  - up=0, q > 0: q ← q-1.
  - up=1, q == MAX: q ← 0 if SATURATE=0; q holds MAX if SATURATE=1.
  - up=0, q == 0: q ← MAX if SATURATE=0; q holds 0 if SATURATE=1.
- A wrap never passes through codes ≥ MODULUS. When MODULUS = 2^WIDTH, wrap coincides with natural rollover.
- tc = rst & enable & ~load & ((up & q==MAX) | (~up & q==0)). It marks the cycle in which the next edge wraps or saturates.
- ovf:
  - Set on any edge where tc is high.
  - Cleared on an edge where clr_ovf is high and tc is low.
  - If tc and clr_ovf are high together, set wins and ovf = 1.
  - Holds otherwise.
- Toggling up while enabled takes effect on the next edge with no dead cycle.
- SATURATE=1 with enable held at a bound:
  - q stays at the bound.
  - tc stays high every cycle.
  - ovf stays set.

## Timing
- All state changes on the rising edge of clk; no asynchronous paths.
- Reset values: q = 0, ovf = 0, tc = 0 (tc is forced low while rst is low).
- Latency:
  - q reflects load or count one edge after the strobe is sampled.
  - ovf reflects a tc event one edge after it.
- tc is combinational from q, enable, up, load and rst; valid in the same cycle, before the edge it predicts.
- rst is synchronous: deasserting rst mid-cycle has no effect until the next edge. Reset asserted mid-count zeroes q on that edge, overriding a simultaneous load.
- Sustained throughput: one count per clock while enable is high.

## Test plan
- Reset: drive rst=0 for 2 edges with load=1, d=5 → q=0, ovf=0, tc=0. Release rst with enable=0 → q holds 0.
- Up count with wrap, WIDTH=4, MODULUS=10, SATURATE=0:
  - From 0, enable=1, up=1 for 10 edges → q runs 1..9 then 0.
  - tc is high only while q=9.
  - ovf rises on the edge where q goes 9→0.
- Down count with saturate, MODULUS=10, SATURATE=1:
  - load d=2, then enable=1, up=0 → q = 1, 0, 0, 0.
  - tc is high from q=0 onward.
  - ovf = 1 one edge after q first reaches 0.
- Load priority and clamp, MODULUS=10:
  - load=1, enable=1, d=13 → q=9 next edge.
  - load d=4 with enable=1 → q=4, not 5.
  - load never sets ovf.
- ovf clear race:
  - With ovf=1, clr_ovf=1 and tc=0 → ovf=0.
  - With q=MAX, up=1, enable=1 and clr_ovf=1 together → ovf stays 1.
- Direction change: MODULUS=16 at q=7, toggle up 1→0 between edges → sequence 8, 7, 6 with no stall cycle.

Source files
------------

// File: rtl/tff_counter_if.sv
// Control and status bundle for tff_counter.
// The bench or parent datapath drives the master side; the counter is the slave.
interface tff_counter_if #(
  parameter int WIDTH = 4
);
  logic             enable;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] d;
  logic             clr_ovf;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             ovf;

  modport master (
    output enable, up, load, d, clr_ovf,
    input  q, tc, ovf
  );

  modport slave (
    input  enable, up, load, d, clr_ovf,
    output q, tc, ovf
  );
endinterface

// File: rtl/tff_counter.sv
// Modulo-MODULUS up/down counter with clamped parallel load, wrap or saturate at
// the bounds, combinational terminal count and a sticky overflow flag.
module tff_counter #(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 16,
  parameter int SATURATE = 0
) (
  input  logic          clk,
  input  logic          rst,
  tff_counter_if.slave  bus
);
  localparam logic [WIDTH-1:0] MAX  = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [WIDTH-1:0] q_r;
  logic             ovf_r;
  logic [WIDTH-1:0] next_q_s;
  logic             tc_s;

  // Terminal count: the next edge will wrap or saturate.
  always_comb begin
    tc_s = 1'b0;
    if (rst && bus.enable && !bus.load) begin
      if (bus.up) begin
        tc_s = (q_r == MAX);
      end else begin
        tc_s = (q_r == ZERO);
      end
    end else begin
      tc_s = 1'b0;
    end
  end

  // Next count: load clamps to MAX, counting wraps within 0..MAX or holds at a bound.
  always_comb begin
    next_q_s = q_r;
    if (bus.load) begin
      if (bus.d > MAX) begin
        next_q_s = MAX;
      end else begin
        next_q_s = bus.d;
      end
    end else if (bus.enable) begin
      if (bus.up) begin
        if (q_r == MAX) begin
          next_q_s = (SATURATE != 0) ? MAX : ZERO;
        end else begin
          next_q_s = q_r + ONE;
        end
      end else begin
        if (q_r == ZERO) begin
          next_q_s = (SATURATE != 0) ? ZERO : MAX;
        end else begin
          next_q_s = q_r - ONE;
        end
      end
    end else begin
      next_q_s = q_r;
    end
  end

  // Count register and sticky overflow; a set from tc beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      q_r   <= ZERO;
      ovf_r <= 1'b0;
    end else begin
      q_r <= next_q_s;
      if (tc_s) begin
        ovf_r <= 1'b1;
      end else if (bus.clr_ovf) begin
        ovf_r <= 1'b0;
      end else begin
        ovf_r <= ovf_r;
      end
    end
  end

  assign bus.q   = q_r;
  assign bus.tc  = tc_s;
  assign bus.ovf = ovf_r;
endmodule

// File: tb/tb_tff_counter.sv
// Directed bench for tff_counter: three instances (wrap mod 10, saturate mod 10,
// wrap mod 16) share one stimulus set; each phase checks the relevant instance.
module tb_tff_counter;
  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       up;
  logic       load;
  logic [3:0] d;
  logic       clr_ovf;

  int n_checks = 0;
  int n_fail   = 0;

  tff_counter_if #(.WIDTH(4)) if_wrap ();
  tff_counter_if #(.WIDTH(4)) if_sat ();
  tff_counter_if #(.WIDTH(4)) if_m16 ();

  assign if_wrap.enable = enable;  assign if_sat.enable = enable;  assign if_m16.enable = enable;
  assign if_wrap.up = up;          assign if_sat.up = up;          assign if_m16.up = up;
  assign if_wrap.load = load;      assign if_sat.load = load;      assign if_m16.load = load;
  assign if_wrap.d = d;            assign if_sat.d = d;            assign if_m16.d = d;
  assign if_wrap.clr_ovf = clr_ovf; assign if_sat.clr_ovf = clr_ovf; assign if_m16.clr_ovf = clr_ovf;

  tff_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_wrap (.clk(clk), .rst(rst), .bus(if_wrap));
  tff_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) u_sat  (.clk(clk), .rst(rst), .bus(if_sat));
  tff_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(0)) u_m16  (.clk(clk), .rst(rst), .bus(if_m16));

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; load = 1'b1; d = 4'd5; enable = 1'b0; up = 1'b1; clr_ovf = 1'b0;
    tick(); tick();
    check("rst_q", int'(if_wrap.q), 0);
    check("rst_ovf", int'(if_wrap.ovf), 0);
    check("rst_tc", int'(if_wrap.tc), 0);
    load = 1'b0; enable = 1'b1; up = 1'b0; #1;
    check("rst_tc_forced", int'(if_wrap.tc), 0);

    rst = 1'b1; enable = 1'b0; up = 1'b1; #1;
    tick();
    check("rel_hold0", int'(if_wrap.q), 0);
    tick();
    check("rel_hold1", int'(if_wrap.q), 0);

    // up count with wrap on MODULUS=10
    enable = 1'b1; up = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      #1;
      check($sformatf("up_tc%0d", i), int'(if_wrap.tc), ((i - 1) == 9) ? 1 : 0);
      tick();
      check($sformatf("up_q%0d", i), int'(if_wrap.q), i % 10);
      check($sformatf("up_ovf%0d", i), int'(if_wrap.ovf), (i == 10) ? 1 : 0);
    end
    check("sat_hold_max", int'(if_sat.q), 9);
    check("sat_tc_at_max", int'(if_sat.tc), 1);

    // load does not touch ovf; then set-wins race with clr_ovf
    enable = 1'b0; load = 1'b1; d = 4'd9;
    tick();
    check("ld9_q", int'(if_wrap.q), 9);
    check("ld9_ovf_kept", int'(if_wrap.ovf), 1);
    load = 1'b0; enable = 1'b1; up = 1'b1; clr_ovf = 1'b1; #1;
    check("race_tc", int'(if_wrap.tc), 1);
    tick();
    check("race_q", int'(if_wrap.q), 0);
    check("race_ovf", int'(if_wrap.ovf), 1);
    enable = 1'b0; clr_ovf = 1'b1;
    tick();
    check("clr_ovf", int'(if_wrap.ovf), 0);
    check("clr_ovf_sat", int'(if_sat.ovf), 0);
    clr_ovf = 1'b0;

    // down count with saturate on MODULUS=10
    load = 1'b1; d = 4'd2; enable = 1'b1;
    tick();
    check("sat_ld2", int'(if_sat.q), 2);
    load = 1'b0; up = 1'b0; #1;
    check("sat_tc_q2", int'(if_sat.tc), 0);
    tick();
    check("sat_q1", int'(if_sat.q), 1);
    check("sat_ovf_q1", int'(if_sat.ovf), 0);
    tick();
    check("sat_q0", int'(if_sat.q), 0);
    check("sat_ovf_q0", int'(if_sat.ovf), 0);
    check("sat_tc_q0", int'(if_sat.tc), 1);
    tick();
    check("sat_hold0a", int'(if_sat.q), 0);
    check("sat_ovf_set", int'(if_sat.ovf), 1);
    tick();
    check("sat_hold0b", int'(if_sat.q), 0);
    check("sat_tc_held", int'(if_sat.tc), 1);
    check("sat_ovf_held", int'(if_sat.ovf), 1);
    check("wrap_down_q", int'(if_wrap.q), 8);

    // load priority over enable, clamp above MAX
    enable = 1'b0; clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("pre_ld_ovf", int'(if_wrap.ovf), 0);
    load = 1'b1; enable = 1'b1; up = 1'b1; d = 4'd13; #1;
    check("ld_tc_low", int'(if_wrap.tc), 0);
    tick();
    check("ld_clamp", int'(if_wrap.q), 9);
    check("ld_clamp_m16", int'(if_m16.q), 13);
    check("ld_clamp_ovf", int'(if_wrap.ovf), 0);
    d = 4'd4;
    tick();
    check("ld_prio", int'(if_wrap.q), 4);
    check("ld_prio_ovf", int'(if_wrap.ovf), 0);

    // direction change on MODULUS=16
    d = 4'd7;
    tick();
    check("dir_ld7", int'(if_m16.q), 7);
    load = 1'b0; enable = 1'b1; up = 1'b1;
    tick();
    check("dir_q8", int'(if_m16.q), 8);
    up = 1'b0;
    tick();
    check("dir_q7", int'(if_m16.q), 7);
    tick();
    check("dir_q6", int'(if_m16.q), 6);

    // reset mid-count overrides a simultaneous load
    rst = 1'b0; load = 1'b1; d = 4'd3;
    tick();
    check("rst_over_load", int'(if_m16.q), 0);
    check("rst_over_load_ovf", int'(if_sat.ovf), 0);
    rst = 1'b1; load = 1'b0; enable = 1'b0;
    tick();
    check("post_rst_hold", int'(if_m16.q), 0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end
endmodule
